btn_cond: RTL and testbench

//   Input conditioner for two mechanical push-buttons on the board.
//   - Synchronises each raw button into clk.
//   - Debounces each button and drives clean levels a/b into the control FSM downstream.
//   - Optionally emits a one-cycle press pulse per button.

---
 rtl/btn_cond_pkg.sv | 21 ++
 rtl/btn_debounce_ch.sv | 126 ++++++++++++
 rtl/btn_cond.sv | 56 +++++
 tb/tb_btn_cond.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_cond_pkg
//  Description : Shared debounce state encodings and board-clock defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_cond_pkg;

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_RISE = 2'b01,
        ST_HIGH = 2'b10,
        ST_FALL = 2'b11
    } deb_state_t;

    // 10 ms hold time at the 125 MHz board clock
    localparam int unsigned c_deb_cycles_125mhz = 1250000;
    localparam int unsigned c_cnt_w_125mhz      = 21;

endpackage : btn_cond_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_ch
//  Description : One button channel: 2-FF synchroniser, debounce FSM, counter.
//                Press tick present only when BTN_COND_TICK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = c_deb_cycles_125mhz,
    parameter int unsigned CNT_W      = c_cnt_w_125mhz
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level
`ifdef BTN_COND_TICK_EN
    ,
    output logic o_tick
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
`ifdef BTN_COND_TICK_EN
    logic             r_tick;
    logic             w_tick_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
`ifdef BTN_COND_TICK_EN
            r_tick  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
`ifdef BTN_COND_TICK_EN
            r_tick  <= w_tick_nxt;
`endif
        end
    end

    // Any reversal of the synchronised input while counting restarts from LOW/HIGH
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
`ifdef BTN_COND_TICK_EN
        w_tick_nxt  = 1'b0;
`endif
        case (r_state)
            ST_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = ST_RISE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RISE: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_HIGH;
                    w_level_nxt = 1'b1;
`ifdef BTN_COND_TICK_EN
                    w_tick_nxt  = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_FALL;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FALL: begin
                if (r_sync2) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_LOW;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level = r_level;
`ifdef BTN_COND_TICK_EN
    assign o_tick  = r_tick;
`endif

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/btn_cond.sv
`default_nettype none
// ============================================================================
//  Module      : btn_cond
//  Description : Two-button input conditioner (sync + debounce per button).
//                Define BTN_COND_TICK_EN to add the a_tick/b_tick press pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = c_deb_cycles_125mhz,
    parameter int unsigned CNT_W      = c_cnt_w_125mhz
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_a_in,
    input  logic btn_b_in,
    output logic a,
    output logic b
`ifdef BTN_COND_TICK_EN
    ,
    output logic a_tick,
    output logic b_tick
`endif
);

    btn_debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ch_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_a_in),
        .o_level (a)
`ifdef BTN_COND_TICK_EN
        ,
        .o_tick  (a_tick)
`endif
    );

    btn_debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ch_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_b_in),
        .o_level (b)
`ifdef BTN_COND_TICK_EN
        ,
        .o_tick  (b_tick)
`endif
    );

endmodule : btn_cond
`default_nettype wire

// File: tb/tb_btn_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_cond
//  Description : Scoreboard bench for btn_cond (DEB_CYCLES=4, CNT_W=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_cond;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn_a = 1'b0;
    logic btn_b = 1'b0;
    logic a;
    logic b;
    logic a_tick;
    logic b_tick;

    int total = 0;
    int bad   = 0;
    int scn   = 0;

    typedef struct {
        logic a;
        logic b;
        logic at;
        logic bt;
        int   scn;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

`ifndef BTN_COND_TICK_EN
    assign a_tick = 1'b0;
    assign b_tick = 1'b0;
`endif

    btn_cond #(
        .DEB_CYCLES (4),
        .CNT_W      (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_a_in (btn_a),
        .btn_b_in (btn_b),
        .a        (a),
        .b        (b)
`ifdef BTN_COND_TICK_EN
        ,
        .a_tick   (a_tick),
        .b_tick   (b_tick)
`endif
    );

    // One call = one clock: drive inputs, queue the outputs expected after the next edge
    task automatic cyc(input logic r, input logic ia, input logic ib,
                       input logic ea, input logic eb, input logic eat, input logic ebt);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = r;
        btn_a = ia;
        btn_b = ib;
        e.a   = ea;
        e.b   = eb;
        e.at  = eat;
        e.bt  = ebt;
        e.scn = scn;
        q.push_back(e);
    endtask

    task automatic hold(input int n, input logic r, input logic ia, input logic ib,
                        input logic ea, input logic eb);
        for (int i = 0; i < n; i++) cyc(r, ia, ib, ea, eb, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (a !== e.a || b !== e.b) begin
                    bad++;
                    $display("FAIL level s%0d: a=%b b=%b expected a=%b b=%b",
                             e.scn, a, b, e.a, e.b);
                end
`ifdef BTN_COND_TICK_EN
                total++;
                if (a_tick !== e.at || b_tick !== e.bt) begin
                    bad++;
                    $display("FAIL tick s%0d: a_tick=%b b_tick=%b expected a_tick=%b b_tick=%b",
                             e.scn, a_tick, b_tick, e.at, e.bt);
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        // 1: reset with both buttons held, then 7 edges to both levels
        scn = 1;
        hold(3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        hold(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        hold(6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: clean press and release of A
        scn = 2;
        hold(6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: 3-cycle glitch on B never reaches the output
        scn = 3;
        hold(3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: bounce on A, count restarts from the last 0->1
        scn = 4;
        hold(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: simultaneous press of both buttons
        scn = 5;
        hold(6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        hold(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        hold(6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: reset while A is counting (cnt=2 in RISE), button kept held
        scn = 6;
        hold(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_btn_cond
`default_nettype wire
